ex_mem_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. It generates stall and flush enables for the IF, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage operand forwarding selects. It freezes the pipeline while a data-memory access in MEM waits on the memory's ready signal, and a timeout FSM locks the core into an error state. It also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/ex_mem_hazard_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ex_mem_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_hazard_ctrl
// Description : Pipeline sequencing controller for a 5-stage RISC-V core.
//               Produces stall/flush/bubble enables for the pipeline
//               registers and EX-stage forwarding selects. The pipeline is
//               frozen while a MEM-stage data access waits on dmem_ready_i.
//               If the wait runs too long, a timeout FSM locks the core into
//               ERROR. A saturating counter records stalled cycles.
// Ports       : clk_i, rst_i (async, active-low)
//               rs1D_i/rs2D_i, rs1E_i/rs2E_i, rdE_i/rdM_i/rdW_i : reg ids
//               resultsrcE_i/resultsrcM_i (01 = load), pcsrcE_i,
//               regwriteM_i/regwriteW_i, memwriteM_i, dmem_ready_i
//               stallF_o/D/E/M, flushD_o/E, bubbleW_o : pipeline control
//               forwardAE_o/forwardBE_o : 00 RF, 01 WB, 10 MEM
//               state_o (00 RUN, 01 MEM_WAIT, 10 ERROR), timeout_o,
//               stall_cnt_o : saturating count of cycles with stallF_o=1
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [4:0]        rs1D_i,
  input  logic [4:0]        rs2D_i,
  input  logic [4:0]        rs1E_i,
  input  logic [4:0]        rs2E_i,
  input  logic [4:0]        rdE_i,
  input  logic [4:0]        rdM_i,
  input  logic [4:0]        rdW_i,
  input  logic [1:0]        resultsrcE_i,
  input  logic              pcsrcE_i,
  input  logic              regwriteM_i,
  input  logic              regwriteW_i,
  input  logic [1:0]        resultsrcM_i,
  input  logic              memwriteM_i,
  input  logic              dmem_ready_i,
  output logic              stallF_o,
  output logic              stallD_o,
  output logic              stallE_o,
  output logic              stallM_o,
  output logic              flushD_o,
  output logic              flushE_o,
  output logic              bubbleW_o,
  output logic [1:0]        forwardAE_o,
  output logic [1:0]        forwardBE_o,
  output logic [1:0]        state_o,
  output logic              timeout_o,
  output logic [PERF_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0]  c_TIMEOUT   = CNT_W'(MEM_TIMEOUT);
  localparam logic [PERF_W-1:0] c_STALL_MAX = {PERF_W{1'b1}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic [CNT_W-1:0]  w_wait_cnt_nxt;
  logic              r_timeout;
  logic              w_timeout_nxt;
  logic [PERF_W-1:0] r_stall_cnt;

  logic       w_memacc;
  logic       w_memwait;
  logic       w_lwstall;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_stallF, w_stallD, w_stallE, w_stallM;
  logic       w_flushD, w_flushE, w_bubbleW;

  // ---------------------------------------------------------------------
  // Hazard terms
  // ---------------------------------------------------------------------
  assign w_memacc  = (resultsrcM_i == 2'b01) | memwriteM_i;
  assign w_memwait = w_memacc & ~dmem_ready_i;
  assign w_lwstall = (resultsrcE_i == 2'b01) & (rdE_i != 5'd0) &
                     ((rdE_i == rs1D_i) | (rdE_i == rs2D_i));

  // MEM result is newer than WB, so it wins when both match.
  always_comb begin
    w_fwd_a = 2'b00;
    if (regwriteM_i && (rdM_i != 5'd0) && (rdM_i == rs1E_i))
      w_fwd_a = 2'b10;
    else if (regwriteW_i && (rdW_i != 5'd0) && (rdW_i == rs1E_i))
      w_fwd_a = 2'b01;
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (regwriteM_i && (rdM_i != 5'd0) && (rdM_i == rs2E_i))
      w_fwd_b = 2'b10;
    else if (regwriteW_i && (rdW_i != 5'd0) && (rdW_i == rs2E_i))
      w_fwd_b = 2'b01;
  end

  // ---------------------------------------------------------------------
  // FSM next-state and pipeline-control outputs
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_timeout_nxt  = r_timeout;
    w_stallF  = 1'b0;
    w_stallD  = 1'b0;
    w_stallE  = 1'b0;
    w_stallM  = 1'b0;
    w_flushD  = 1'b0;
    w_flushE  = 1'b0;
    w_bubbleW = 1'b0;

    case (r_state)
      ST_RUN, ST_MEM_WAIT: begin
        if (w_memwait) begin
          // Freeze everything up to MEM; branch/load-use hazards stay
          // latched in EX and are acted on once the access completes.
          w_stallF  = 1'b1;
          w_stallD  = 1'b1;
          w_stallE  = 1'b1;
          w_stallM  = 1'b1;
          w_bubbleW = 1'b1;
        end else begin
          w_stallF = w_lwstall;
          w_stallD = w_lwstall;
          w_flushE = w_lwstall | pcsrcE_i;
          w_flushD = pcsrcE_i;
        end

        if (!w_memwait) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_state == ST_RUN) begin
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = CNT_W'(1);
        end else if (r_wait_cnt == c_TIMEOUT) begin
          w_state_nxt   = ST_ERROR;
          w_timeout_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
        end
      end

      ST_ERROR: begin
        w_stallF  = 1'b1;
        w_stallD  = 1'b1;
        w_stallE  = 1'b1;
        w_stallM  = 1'b1;
        w_bubbleW = 1'b1;
      end

      default: begin
        w_state_nxt    = ST_RUN;
        w_wait_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      r_stall_cnt <= '0;
    else if (w_stallF && (r_stall_cnt != c_STALL_MAX))
      r_stall_cnt <= r_stall_cnt + PERF_W'(1);
  end

  // ---------------------------------------------------------------------
  // Outputs: control enables are held inactive while reset is asserted,
  // independent of any clock edge.
  // ---------------------------------------------------------------------
  assign stallF_o    = rst_i & w_stallF;
  assign stallD_o    = rst_i & w_stallD;
  assign stallE_o    = rst_i & w_stallE;
  assign stallM_o    = rst_i & w_stallM;
  assign flushD_o    = rst_i & w_flushD;
  assign flushE_o    = rst_i & w_flushE;
  assign bubbleW_o   = rst_i & w_bubbleW;
  assign forwardAE_o = rst_i ? w_fwd_a : 2'b00;
  assign forwardBE_o = rst_i ? w_fwd_b : 2'b00;
  assign state_o     = r_state;
  assign timeout_o   = r_timeout;
  assign stall_cnt_o = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_hazard_ctrl
// Description : Self-checking bench for ex_mem_hazard_ctrl. A behavioural
//               model tracks the run of consecutive memory-wait cycles, the
//               error lock and the stall count; every negedge all outputs
//               are compared against it. Directed literal checks pin key
//               points of the expected behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_hazard_ctrl;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;
  localparam int PERF_W      = 16;
  localparam int c_CNT_MAX   = (1 << PERF_W) - 1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [4:0]  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i;
  logic [1:0]  resultsrcE_i, resultsrcM_i;
  logic        pcsrcE_i, regwriteM_i, regwriteW_i, memwriteM_i, dmem_ready_i;
  logic        stallF_o, stallD_o, stallE_o, stallM_o;
  logic        flushD_o, flushE_o, bubbleW_o, timeout_o;
  logic [1:0]  forwardAE_o, forwardBE_o, state_o;
  logic [PERF_W-1:0] stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W), .PERF_W(PERF_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1D_i(rs1D_i), .rs2D_i(rs2D_i), .rs1E_i(rs1E_i), .rs2E_i(rs2E_i),
    .rdE_i(rdE_i), .rdM_i(rdM_i), .rdW_i(rdW_i),
    .resultsrcE_i(resultsrcE_i), .pcsrcE_i(pcsrcE_i),
    .regwriteM_i(regwriteM_i), .regwriteW_i(regwriteW_i),
    .resultsrcM_i(resultsrcM_i), .memwriteM_i(memwriteM_i),
    .dmem_ready_i(dmem_ready_i),
    .stallF_o(stallF_o), .stallD_o(stallD_o), .stallE_o(stallE_o),
    .stallM_o(stallM_o), .flushD_o(flushD_o), .flushE_o(flushE_o),
    .bubbleW_o(bubbleW_o), .forwardAE_o(forwardAE_o),
    .forwardBE_o(forwardBE_o), .state_o(state_o), .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------
  int m_consec = 0;   // consecutive memwait cycles already completed
  bit m_err    = 0;
  int m_cnt    = 0;

  logic       e_memwait, e_lw;
  logic       e_stallF, e_stallD, e_stallE, e_stallM;
  logic       e_flushD, e_flushE, e_bubbleW, e_to;
  logic [1:0] e_fa, e_fb, e_state;

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (regwriteM_i && rdM_i != 0 && rdM_i == rs) return 2'b10;
    if (regwriteW_i && rdW_i != 0 && rdW_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @* begin
    e_memwait = ((resultsrcM_i == 2'b01) || memwriteM_i) && !dmem_ready_i;
    e_lw = (resultsrcE_i == 2'b01) && rdE_i != 0 &&
           (rdE_i == rs1D_i || rdE_i == rs2D_i);
    e_fa = fwd(rs1E_i);
    e_fb = fwd(rs2E_i);
    e_state = m_err ? 2'b10 : (m_consec > 0 ? 2'b01 : 2'b00);
    e_to = m_err;
    e_stallF = 0; e_stallD = 0; e_stallE = 0; e_stallM = 0;
    e_flushD = 0; e_flushE = 0; e_bubbleW = 0;
    if (m_err || e_memwait) begin
      e_stallF = 1; e_stallD = 1; e_stallE = 1; e_stallM = 1; e_bubbleW = 1;
    end else begin
      e_stallF = e_lw; e_stallD = e_lw;
      e_flushE = e_lw | pcsrcE_i;
      e_flushD = pcsrcE_i;
    end
    if (!rst_i) begin
      e_stallF = 0; e_stallD = 0; e_stallE = 0; e_stallM = 0;
      e_flushD = 0; e_flushE = 0; e_bubbleW = 0; e_fa = 0; e_fb = 0;
    end
  end

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_consec <= 0; m_err <= 0; m_cnt <= 0;
    end else begin
      if (e_stallF && m_cnt < c_CNT_MAX) m_cnt <= m_cnt + 1;
      if (!m_err) begin
        if (!e_memwait)                   m_consec <= 0;
        else if (m_consec == MEM_TIMEOUT) m_err    <= 1;
        else                              m_consec <= m_consec + 1;
      end
    end
  end

  always @(negedge clk_i) begin
    chk("stallF",  stallF_o,    e_stallF);
    chk("stallD",  stallD_o,    e_stallD);
    chk("stallE",  stallE_o,    e_stallE);
    chk("stallM",  stallM_o,    e_stallM);
    chk("flushD",  flushD_o,    e_flushD);
    chk("flushE",  flushE_o,    e_flushE);
    chk("bubbleW", bubbleW_o,   e_bubbleW);
    chk("fwdA",    forwardAE_o, e_fa);
    chk("fwdB",    forwardBE_o, e_fb);
    chk("state",   state_o,     e_state);
    chk("timeout", timeout_o,   e_to);
    chk("stallcnt", stall_cnt_o, m_cnt);
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  task automatic cyc; @(posedge clk_i); #1; endtask
  task automatic mid; @(negedge clk_i); #1; endtask

  task automatic clear_inputs;
    rs1D_i = 0; rs2D_i = 0; rs1E_i = 0; rs2E_i = 0;
    rdE_i = 0; rdM_i = 0; rdW_i = 0;
    resultsrcE_i = 0; resultsrcM_i = 0; pcsrcE_i = 0;
    regwriteM_i = 0; regwriteW_i = 0; memwriteM_i = 0; dmem_ready_i = 1;
  endtask

  initial begin
    clear_inputs();
    // Reset with hazards present: control outputs must stay 0.
    regwriteM_i = 1; rdM_i = 5; rs1E_i = 5;
    resultsrcE_i = 2'b01; rdE_i = 3; rs2D_i = 3;
    mid();
    chk("rst_state",  state_o, 0);
    chk("rst_cnt",    stall_cnt_o, 0);
    chk("rst_to",     timeout_o, 0);
    chk("rst_fwdA",   forwardAE_o, 0);
    chk("rst_stallF", stallF_o, 0);
    resultsrcE_i = 0; rdE_i = 0; rs2D_i = 0;
    rst_i = 1;

    // Forwarding priority
    regwriteW_i = 1; rdW_i = 5;
    #1 chk("fwdA_mem", forwardAE_o, 2'b10);
    rdM_i = 0;
    #1 chk("fwdA_wb", forwardAE_o, 2'b01);
    rs2E_i = 7;
    #1 chk("fwdB_none", forwardBE_o, 2'b00);

    // Load-use: one stall cycle, then clear
    cyc(); clear_inputs();
    resultsrcE_i = 2'b01; rdE_i = 3; rs2D_i = 3;
    mid();
    chk("lu_stallF", stallF_o, 1);
    chk("lu_stallD", stallD_o, 1);
    chk("lu_flushE", flushE_o, 1);
    chk("lu_flushD", flushD_o, 0);
    cyc(); clear_inputs(); resultsrcM_i = 2'b01; rdM_i = 3;
    mid();
    chk("lu2_stallF", stallF_o, 0);
    chk("lu2_flushE", flushE_o, 0);
    chk("lu2_cnt",    stall_cnt_o, 1);

    // Branch and load-use together
    cyc(); clear_inputs();
    pcsrcE_i = 1; resultsrcE_i = 2'b01; rdE_i = 3; rs1D_i = 3;
    mid();
    chk("br_flushD", flushD_o, 1);
    chk("br_flushE", flushE_o, 1);
    chk("br_stallF", stallF_o, 1);
    chk("br_stallD", stallD_o, 1);

    // Memory wait: 3 wait cycles then ready, branch held throughout
    cyc(); clear_inputs();
    mid(); rst_i = 0; #2 rst_i = 1;
    cyc(); memwriteM_i = 1; dmem_ready_i = 0; pcsrcE_i = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("mw_state",  state_o, (i == 0) ? 0 : 1);
      chk("mw_stallM", stallM_o, 1);
      chk("mw_bubble", bubbleW_o, 1);
      chk("mw_flushD", flushD_o, 0);
      cyc();
    end
    dmem_ready_i = 1;
    mid();
    chk("mw_rel_state",  state_o, 1);
    chk("mw_rel_stallF", stallF_o, 0);
    chk("mw_rel_flushD", flushD_o, 1);
    chk("mw_rel_flushE", flushE_o, 1);
    chk("mw_rel_cnt",    stall_cnt_o, 3);
    cyc(); clear_inputs();
    mid();
    chk("mw_after_state", state_o, 0);

    // Timeout: load waits forever
    rst_i = 0; #2 rst_i = 1;
    cyc(); resultsrcM_i = 2'b01; dmem_ready_i = 0;
    for (int i = 1; i <= 16; i++) begin
      mid();
      if (i == 16) begin
        chk("to_pre_state", state_o, 1);
        chk("to_pre_to",    timeout_o, 0);
      end
      cyc();
    end
    mid();
    chk("to_state",  state_o, 2'b10);
    chk("to_to",     timeout_o, 1);
    chk("to_stallE", stallE_o, 1);
    chk("to_cnt",    stall_cnt_o, 16);
    dmem_ready_i = 1;
    cyc(); mid();
    chk("to_abs_state",  state_o, 2'b10);
    chk("to_abs_stallF", stallF_o, 1);
    rst_i = 0; #2 rst_i = 1; #1;
    chk("to_rst_state", state_o, 0);
    chk("to_rst_to",    timeout_o, 0);
    chk("to_rst_cnt",   stall_cnt_o, 0);

    // Ready arriving in the 16th wait cycle returns to RUN
    cyc(); clear_inputs(); resultsrcM_i = 2'b01; dmem_ready_i = 0;
    repeat (15) cyc();
    dmem_ready_i = 1;
    mid();
    chk("bd_state",  state_o, 1);
    chk("bd_stallF", stallF_o, 0);
    cyc(); mid();
    chk("bd_state2", state_o, 0);
    chk("bd_to",     timeout_o, 0);

    // Asynchronous reset in the middle of MEM_WAIT
    cyc(); clear_inputs(); memwriteM_i = 1; dmem_ready_i = 0;
    cyc(); cyc();
    mid();
    chk("aw_state", state_o, 1);
    rst_i = 0; #1;
    chk("aw_async_state",  state_o, 0);
    chk("aw_async_stallF", stallF_o, 0);
    chk("aw_async_bubble", bubbleW_o, 0);
    chk("aw_async_cnt",    stall_cnt_o, 0);
    memwriteM_i = 0; dmem_ready_i = 1;
    #1 rst_i = 1;
    cyc();
    chk("aw_run", state_o, 0);

    mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
